// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline stage registers.
// The state code doubles as the entry count.
package pipeline_pkg;

    localparam logic [1:0] ST_EMPTY     = 2'd0;
    localparam logic [1:0] ST_FULL      = 2'd1;
    localparam logic [1:0] ST_SKID_FULL = 2'd2;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush-to-bubble and an optional
// 2-entry skid buffer that makes IN_READY a flop.
module pipe_stage_reg #(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int                    SKID         = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  FLUSH,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [1:0]            OCCUPANCY
);
    import pipeline_pkg::*;

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_s;
    logic                  in_ready_s;
    logic                  out_valid_s;
    logic                  push_s;
    logic                  pop_s;

    assign out_valid_s = (state_q != ST_EMPTY);
    assign pop_s       = out_valid_s & OUT_READY;
    assign push_s      = IN_VALID & in_ready_s;

    // Next-state and main-register selection; FLUSH drops the input beat.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d = ST_FULL;
                        main_d  = IN_DATA;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (push_s && pop_s) begin
                        main_d = IN_DATA;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else if (push_s && (SKID != 0)) begin
                        state_d = ST_SKID_FULL;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID_FULL: begin
                    if (pop_s) begin
                        state_d = ST_FULL;
                        main_d  = skid_s;
                    end else begin
                        state_d = ST_SKID_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and head-entry registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_WIDTH-1:0] skid_q;
            logic [DATA_WIDTH-1:0] skid_d;
            logic                  in_ready_q;
            logic                  in_ready_d;

            // Skid captures the beat that arrives while the head is stalled.
            always_comb begin
                skid_d     = skid_q;
                in_ready_d = (state_d != ST_SKID_FULL);
                if (FLUSH) begin
                    skid_d = BUBBLE_VALUE;
                end else if ((state_q == ST_FULL) && push_s && !pop_s) begin
                    skid_d = IN_DATA;
                end else begin
                    skid_d = skid_q;
                end
            end

            // Skid register and registered ready.
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    skid_q     <= BUBBLE_VALUE;
                    in_ready_q <= 1'b0;
                end else begin
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign skid_s     = skid_q;
            assign in_ready_s = in_ready_q & RESET;
        end else begin : g_noskid
            logic rst_done_q;

            // Holds ready low until the first edge after reset release.
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    rst_done_q <= 1'b0;
                end else begin
                    rst_done_q <= 1'b1;
                end
            end

            assign skid_s     = BUBBLE_VALUE;
            assign in_ready_s = RESET & rst_done_q & (!out_valid_s | OUT_READY);
        end
    endgenerate

    assign IN_READY  = in_ready_s;
    assign OUT_VALID = out_valid_s;
    assign OUT_DATA  = out_valid_s ? main_q : BUBBLE_VALUE;
    assign OCCUPANCY = state_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the RV32IM pipeline, used between IF/ID, ID/EX, EX/MEM and MEM/WB in place of fixed-width, free-running stage registers. Carries an arbitrary-width payload (e.g. instruction + PC+4) with valid/ready flow control, hazard-driven stall via backpressure, flush-to-bubble, and an optional 2-entry skid buffer that removes the combinational ready path between stages.

## Interface
- DATA_WIDTH, 64, payload width in bits (IF/ID: instruction[63:32], PC+4[31:0]).
- BUBBLE_VALUE, 0 (DATA_WIDTH bits), value driven on OUT_DATA whenever OUT_VALID=0. For IF/ID, instantiate with NOP (0x00000013) in the instruction field.
- SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single entry with combinational IN_READY.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- IN_DATA  in  DATA_WIDTH  upstream payload.
- IN_VALID  in  1  upstream payload valid.
- IN_READY  out  1  stage can accept; a transfer occurs when IN_VALID & IN_READY.
- FLUSH  in  1  synchronous squash of all held entries and of the current input transfer.
- OUT_DATA  out  DATA_WIDTH  head payload, or BUBBLE_VALUE when empty.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  downstream accepts; pop when OUT_VALID & OUT_READY.
- OCCUPANCY  out  2  entries held (0..2; never exceeds 1 when SKID=0).

## Operation
- States: EMPTY (occ 0), FULL (main only, occ 1), SKID_FULL (main + skid, occ 2; SKID=1 only).
- Priority each edge: RESET low > FLUSH > normal push/pop.
- EMPTY: push -> FULL, main <= IN_DATA.
- FULL: push & pop -> FULL, main <= IN_DATA. Pop only -> EMPTY. Push only -> SKID_FULL with skid <= IN_DATA when SKID=1; cannot occur when SKID=0 (IN_READY=0).
- SKID_FULL: pop -> FULL, main <= skid. No push possible.
- IN_READY: SKID=1: registered, equals (state != SKID_FULL). SKID=0: combinational, !OUT_VALID | OUT_READY.
- OUT_VALID = (state != EMPTY); OUT_DATA = main when valid, else BUBBLE_VALUE.
- FLUSH: next state EMPTY and skid cleared. An input handshake coincident with FLUSH is discarded. A pop coincident with FLUSH still completes downstream (the entry was already presented).
- Data ordering is strictly FIFO; no entry is duplicated or dropped except by FLUSH.

## Timing
- Reset (RESET low at an edge): state EMPTY, OUT_VALID=0, OUT_DATA=BUBBLE_VALUE, OCCUPANCY=0. IN_READY=0 while RESET is low, and 1 from the first edge after release.
- Latency: data accepted at edge N appears on OUT_DATA/OUT_VALID after edge N, visible in cycle N+1.
- Throughput: one transfer per cycle with OUT_READY held high, in both SKID modes.
- SKID=1: OUT_READY deasserting absorbs at most one in-flight beat in skid; IN_READY falls the cycle after. No combinational path from OUT_READY to IN_READY.
- Reset asserted mid-operation discards all entries at that edge; FLUSH and RESET together behave as reset.

## Structure
- Shared package `pipeline_pkg`: state encoding (EMPTY/FULL/SKID_FULL localparams, 2-bit), NOP constant 32'h00000013.
- Single module; no sub-module. Main and skid registers are inline, and the skid register is generated only when SKID=1.

## Test plan
- Reset/stream: RESET low 2 cycles, then push 100|104, 200|204, 300|304 on consecutive cycles with OUT_READY=1 -> each appears on OUT_DATA one cycle later, OUT_VALID=1, IN_READY=1 throughout. During reset: OUT_DATA=BUBBLE_VALUE, OCCUPANCY=0.
- Backpressure (SKID=1): stream with OUT_READY dropped for 3 cycles -> OCCUPANCY goes 1->2, IN_READY=0 the cycle after the drop, OUT_DATA holds the head. On release, order is preserved with no loss.
- Backpressure (SKID=0): same stimulus -> IN_READY tracks OUT_READY combinationally, OCCUPANCY never exceeds 1.
- Flush: with OCCUPANCY=2, assert FLUSH with IN_VALID=1 and IN_DATA=500|504 -> next cycle OUT_VALID=0, OUT_DATA=NOP bubble, and 500 is never emitted.
- Reset mid-stream: RESET low while OCCUPANCY=2 -> EMPTY next edge, IN_READY=0 until release, and the first push after release emerges correctly.
